// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell reused per cycle.
// Start/busy/done handshake; registered diff, borrow-out, overflow and zero.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             x, y, dbit, nbr, last, accept;
  logic [WIDTH-1:0] d_sh_nxt;

  assign x        = a_sh_q[0];
  assign y        = b_sh_q[0];
  assign dbit     = x ^ y ^ br_q;
  assign nbr      = (~x & y) | (~(x ^ y) & br_q);
  assign last     = (cnt_q == CW'(WIDTH - 1));
  assign d_sh_nxt = (d_sh_q >> 1) | (WIDTH'(dbit) << (WIDTH - 1));

  // The edge leaving DONE is also the first IDLE sample point, so a new
  // operation can issue every WIDTH+1 cycles.
  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          d_sh_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = nbr;
        d_sh_d = d_sh_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          // br_q here is the borrow into the MSB stage
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = d_sh_nxt;
          bout_d  = nbr;
          ovf_d   = br_q ^ nbr;
          zero_d  = (d_sh_nxt == '0);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 table/sequence checks and
// an exhaustive WIDTH=1 run issued at the minimum interval.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
  } vec8_t;

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, start1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy8, done8, bout8, ovf8, zero8;
  logic [7:0] diff8;
  logic       busy1, done1, bout1, ovf1, zero1;
  logic [0:0] diff1;

  int   n_checks = 0;
  int   n_fail = 0;
  int   done1_cnt = 0;
  res_t q8[$];
  res_t q1[$];
  res_t prev;

  vec8_t t8[7];
  vec8_t t1[8];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8),
    .bout(bout8), .ovf(ovf8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1),
    .bout(bout1), .ovf(ovf1), .zero(zero1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    res_t r;
    if (done8) begin
      if (q8.size() == 0) chk("u8 unexpected done", 1, 0);
      else begin
        r = q8.pop_front();
        chk("u8 diff", diff8, r.diff);
        chk("u8 bout", bout8, r.bout);
        chk("u8 ovf", ovf8, r.ovf);
        chk("u8 zero", zero8, r.zero);
      end
    end
    if (done1) begin
      done1_cnt++;
      if (q1.size() == 0) chk("u1 unexpected done", 1, 0);
      else begin
        r = q1.pop_front();
        chk("u1 diff", {7'd0, diff1}, r.diff);
        chk("u1 bout", bout1, r.bout);
        chk("u1 ovf", ovf1, r.ovf);
        chk("u1 zero", zero1, r.zero);
      end
    end
  end

  task automatic chk_hold(input string nm);
    chk({nm, " diff hold"}, diff8, prev.diff);
    chk({nm, " bout hold"}, bout8, prev.bout);
    chk({nm, " ovf hold"}, ovf8, prev.ovf);
    chk({nm, " zero hold"}, zero8, prev.zero);
  endtask

  task automatic run_op(input vec8_t v, input bit glitch);
    @(negedge clk);
    a8 = v.a; b8 = v.b; bin8 = v.bin; start8 = 1'b1;
    q8.push_back('{v.diff, v.bout, v.ovf, v.zero});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) start8 = 1'b0;
      chk("u8 busy in run", busy8, 1);
      chk("u8 done in run", done8, 0);
      chk_hold("u8 run");
      if (glitch && i == 2) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
      end
      if (glitch && i == 3) start8 = 1'b0;
    end
    @(negedge clk);
    chk("u8 done pulse", done8, 1);
    chk("u8 busy at done", busy8, 0);
    prev = '{v.diff, v.bout, v.ovf, v.zero};
    @(negedge clk);
    chk("u8 done one cycle", done8, 0);
    chk("u8 busy after done", busy8, 0);
  endtask

  initial begin
    t8[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0};
    t8[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    t8[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    t8[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    t8[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    t8[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    t8[6] = '{8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0};
    // a, b, bin -> d, bout, ovf = bin ^ bout, zero
    t1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    t1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0};
    t1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0};
    t1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b1};
    t1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0};
    t1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1};
    t1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    t1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0};

    // reset with random inputs and start held high
    rst = 1'b1;
    start8 = 1'b1; start1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
    end
    @(negedge clk);
    chk("rst busy8", busy8, 0);
    chk("rst done8", done8, 0);
    chk("rst diff8", diff8, 0);
    chk("rst bout8", bout8, 0);
    chk("rst ovf8", ovf8, 0);
    chk("rst zero8", zero8, 0);
    chk("rst busy1", busy1, 0);
    chk("rst outs1", {diff1, bout1, ovf1, zero1, done1}, 0);
    rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
    prev = '0;

    for (int i = 0; i < 6; i++) run_op(t8[i], 1'b0);
    run_op(t8[6], 1'b1);

    // mid-run reset: no done, no commit, back to IDLE
    @(negedge clk);
    a8 = 8'h44; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) start8 = 1'b0;
      chk("abort busy", busy8, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy clr", busy8, 0);
    chk("abort outs clr", {diff8, bout8, ovf8, zero8, done8}, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort no done", done8, 0);
      chk("abort idle", busy8, 0);
    end
    prev = '0;
    run_op(t8[0], 1'b0);

    // WIDTH=1 exhaustive, start held, operands changed every 2 cycles
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = t1[i].a[0]; b1 = t1[i].b[0]; bin1 = t1[i].bin;
      start1 = 1'b1;
      q1.push_back('{t1[i].diff, t1[i].bout, t1[i].ovf, t1[i].zero});
      @(negedge clk);
      chk("u1 busy", busy1, 1);
    end
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("u1 done count", done1_cnt, 8);
    chk("u1 queue empty", q1.size(), 0);
    chk("u8 queue empty", q8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
